usbfs_out_sched: RTL
====================

# usbfs_out_sched

Scheduler that shares the transactor's single host-to-device receive buffer between `N_ENDP` OUT endpoint receivers. It decodes the endpoint number of each received DATA packet and routes the valid/ready/stall handshake to that endpoint. It then grants the buffer read port to that endpoint exclusively until every byte of the packet has been read. It sits between the USB transactor and the per-endpoint receive blocks.

## Interface
Parameters:
- `N_ENDP`, 4: number of OUT endpoints, 1..16; endpoint `e` serves USB endpoint number `e`.
- `MAX_PKT`, 8: maximum payload bytes; `IDX_W = $clog2(MAX_PKT)`, `NBYTES_W = $clog2(MAX_PKT+1)`.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_erEndp`  in  4  endpoint number of the pending packet; valid while `i_erValid`.
- `i_erValid`  in  1  transactor has a complete packet in the buffer.
- `o_erReady`  out  1  packet accepted when `o_erReady && i_erValid`.
- `o_erStall`  out  1  the addressed endpoint stalls this packet.
- `o_erRdEn`  out  1  buffer read strobe to the transactor.
- `o_erRdIdx`  out  IDX_W  buffer byte index.
- `i_erRdByte`  in  8  byte at the previous cycle's `o_erRdIdx`.
- `i_erRdNBytes`  in  NBYTES_W  payload length of the pending packet.
- `i_epEnable`  in  N_ENDP  per-endpoint enable mask.
- `o_epErValid`  out  N_ENDP  one-hot valid to the endpoints.
- `i_epErReady`  in  N_ENDP  per-endpoint ready.
- `i_epErStall`  in  N_ENDP  per-endpoint stall.
- `i_epRdEn`  in  N_ENDP  per-endpoint read strobe.
- `i_epRdIdx`  in  N_ENDP*IDX_W  per-endpoint read index; endpoint `e` uses slice `[e*IDX_W +: IDX_W]`.
- `o_epRdByte`  out  8  `i_erRdByte`, broadcast to all endpoints.
- `o_epRdNBytes`  out  NBYTES_W  `i_erRdNBytes`, broadcast to all endpoints.
- `o_busy`  out  1  high in DRAIN.

## Operation
- FSM states: IDLE and DRAIN. Registers: `state_q`, `sel_q[3:0]`, `nBytes_q[NBYTES_W-1:0]`, `cnt_q[NBYTES_W-1:0]`.
- `hit = (i_erEndp < N_ENDP) && i_epEnable[i_erEndp]`.
- IDLE outputs:
  - `o_epErValid[e] = i_erValid && hit && (i_erEndp == e)`.
  - `o_erReady = hit && i_epErReady[i_erEndp]`.
  - `o_erStall = !hit || i_epErStall[i_erEndp]`.
  - `o_erRdEn = 0`.
- Non-existent or disabled endpoint: stall asserted, ready low, no valid driven.
- Accept in IDLE:
  - Capture `sel_q = i_erEndp`, `nBytes_q = i_erRdNBytes`, `cnt_q = 0`.
  - If `i_erRdNBytes == 0`, remain in IDLE (zero-length packet); otherwise go to DRAIN.
- DRAIN outputs:
  - `o_erReady = 0` and `o_epErValid = 0`.
  - `o_erStall = i_epErStall[sel_q]`.
  - `o_erRdEn = i_epRdEn[sel_q]`; `o_erRdIdx = i_epRdIdx[sel_q]`.
  - Strobes from non-selected endpoints are ignored.
- Each `o_erRdEn` increments `cnt_q`. The DRAIN→IDLE transition happens on the cycle where `o_erRdEn && (cnt_q + 1 == nBytes_q)`.
- The buffer is not released to the transactor (`o_erReady` stays low) until DRAIN exits. This guarantees no overwrite mid-read.
- `cnt_q` arithmetic is NBYTES_W wide and cannot wrap, because `nBytes_q <= MAX_PKT`.
- The `i_erValid` and `i_erEndp` values presented during DRAIN are held off and are not latched.

## Timing
- Reset values:
  - `state_q = IDLE`; `sel_q`, `nBytes_q` and `cnt_q` are 0.
  - `o_busy = 0`, `o_erRdEn = 0`.
  - Handshake outputs follow the IDLE equations.
- Latency:
  - Handshake outputs are combinational from inputs, with 0 cycles of added latency.
  - `o_busy` rises 1 cycle after accept.
  - Read port mux is combinational from `sel_q`.
- A packet of N bytes, with the endpoint reading every cycle, holds DRAIN for exactly N cycles. `o_erReady` can be high again on cycle N+1 after accept.
- Reset asserted mid-DRAIN forces IDLE asynchronously; `o_erRdEn` drops immediately. A partially read packet is discarded and not replayed.
- Back-to-back packets: the earliest accept of the next packet is the first IDLE cycle after the DRAIN exit cycle.

## Structure
- Package `usbfs_pkg` holds `USB_ENDP_W = 4` and `typedef enum logic {SCHED_IDLE, SCHED_DRAIN} usbfs_sched_state_t`.
- No sub-module is warranted. Index-selection muxes are inline; the design is a single module.

## Test plan
- Endpoint enable and length: `N_ENDP=4`, all enabled, packet to endp 2 with NBytes=5, endp 2 reading every cycle.
  - Required: `o_epErValid=4'b0100`, exactly 5 `o_erRdEn` with idx 0..4, `o_busy` high 5 cycles, then IDLE.
- Out-of-range endpoint: packet to endp 7.
  - Required: `o_erStall=1`, `o_erReady=0`, `o_epErValid=0`, no state change.
- Disabled endpoint: `i_epEnable=4'b1101`, packet to endp 1.
  - Required: stall, no accept. Then enable endp 1: accept proceeds.
- Zero-length packet: packet with NBytes=0 to endp 0.
  - Required: accept, state stays IDLE, `o_busy` never rises, no reads.
- Holdoff and isolation: second `i_erValid` asserted during a DRAIN of 8 bytes with a slow reader (rdEn every 3rd cycle), while endp 3 strobes `i_epRdEn` during the DRAIN.
  - Required: `o_erReady=0` for the whole DRAIN; endp 3's strobes are not forwarded; the second packet is accepted only after the 8th read.
- Reset mid-DRAIN: assert `i_rst` after 2 of 6 reads.
  - Required: `o_erRdEn=0` immediately, `o_busy=0`, and the next packet is accepted normally after reset is released.

Source files
------------

// File: rtl/usbfs_pkg.sv
// Shared constants and types for the USB full-speed transactor blocks.
package usbfs_pkg;

    localparam int USB_ENDP_W = 4;

    typedef enum logic {
        SCHED_IDLE,
        SCHED_DRAIN
    } usbfs_sched_state_t;

endpackage

// File: rtl/usbfs_out_sched.sv
// Shares the single host-to-device receive buffer between N_ENDP OUT endpoint
// receivers: routes the packet handshake, then lends the read port to one endpoint.
module usbfs_out_sched
    import usbfs_pkg::*;
#(
    parameter int  N_ENDP   = 4,
    parameter int  MAX_PKT  = 8,
    localparam int IDX_W    = $clog2(MAX_PKT),
    localparam int NBYTES_W = $clog2(MAX_PKT + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [USB_ENDP_W-1:0]     i_erEndp,
    input  logic                      i_erValid,
    output logic                      o_erReady,
    output logic                      o_erStall,
    output logic                      o_erRdEn,
    output logic [IDX_W-1:0]          o_erRdIdx,
    input  logic [7:0]                i_erRdByte,
    input  logic [NBYTES_W-1:0]       i_erRdNBytes,
    input  logic [N_ENDP-1:0]         i_epEnable,
    output logic [N_ENDP-1:0]         o_epErValid,
    input  logic [N_ENDP-1:0]         i_epErReady,
    input  logic [N_ENDP-1:0]         i_epErStall,
    input  logic [N_ENDP-1:0]         i_epRdEn,
    input  logic [N_ENDP*IDX_W-1:0]   i_epRdIdx,
    output logic [7:0]                o_epRdByte,
    output logic [NBYTES_W-1:0]       o_epRdNBytes,
    output logic                      o_busy
);

    localparam int EP_SLOTS = 1 << USB_ENDP_W;

    usbfs_sched_state_t    state_q, state_d;
    logic [USB_ENDP_W-1:0] sel_q, sel_d;
    logic [NBYTES_W-1:0]   nBytes_q, nBytes_d;
    logic [NBYTES_W-1:0]   cnt_q, cnt_d;

    logic [EP_SLOTS-1:0]   en_pad, rdy_pad, stall_pad, rden_pad;
    logic [IDX_W-1:0]      idx_pad [EP_SLOTS];
    logic                  idle, hit, accept, last_rd;

    // Zero-padding to the full endpoint-number space makes out-of-range numbers read as disabled.
    assign en_pad    = EP_SLOTS'(i_epEnable);
    assign rdy_pad   = EP_SLOTS'(i_epErReady);
    assign stall_pad = EP_SLOTS'(i_epErStall);
    assign rden_pad  = EP_SLOTS'(i_epRdEn);

    for (genvar e = 0; e < EP_SLOTS; e++) begin : g_idx
        if (e < N_ENDP) begin : g_used
            assign idx_pad[e] = i_epRdIdx[e*IDX_W +: IDX_W];
        end else begin : g_unused
            assign idx_pad[e] = '0;
        end
    end

    assign idle         = (state_q == SCHED_IDLE);
    assign hit          = en_pad[i_erEndp];
    assign o_busy       = !idle;
    assign o_epRdByte   = i_erRdByte;
    assign o_epRdNBytes = i_erRdNBytes;
    assign o_erRdIdx    = idx_pad[sel_q];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        o_epErValid = '0;
        for (int e = 0; e < N_ENDP; e++) begin
            o_epErValid[e] = idle && i_erValid && hit && (i_erEndp == USB_ENDP_W'(e));
        end
        o_erReady = idle && hit && rdy_pad[i_erEndp];
        o_erStall = idle ? (!hit || stall_pad[i_erEndp]) : stall_pad[sel_q];
        o_erRdEn  = !idle && rden_pad[sel_q];
    end

    assign accept  = idle && i_erValid && o_erReady;
    assign last_rd = o_erRdEn && ((cnt_q + NBYTES_W'(1)) == nBytes_q);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        nBytes_d = nBytes_q;
        cnt_d    = cnt_q;
        if (accept) begin
            sel_d    = i_erEndp;
            nBytes_d = i_erRdNBytes;
            cnt_d    = '0;
            // A zero-length packet has nothing to read, so the buffer is never lent out.
            state_d  = (i_erRdNBytes == '0) ? SCHED_IDLE : SCHED_DRAIN;
        end else if (o_erRdEn) begin
            cnt_d = cnt_q + NBYTES_W'(1);
            if (last_rd) begin
                state_d = SCHED_IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= SCHED_IDLE;
            sel_q    <= '0;
            nBytes_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            nBytes_q <= nBytes_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
